// File: rtl/aes_pkg.sv
// ----------------------------------------------------------------------------
// aes_pkg
// Shared types and constants for the SPI-to-AES sequencer.
//   TEXT_BITS    : AES block width
//   LEN_W        : width of the cs-low frame length counter (saturates at 511)
//   ctrl_state_e : sequencer state encoding
//   calc_dw()    : SPI data bus width for a given key length in 32-bit words
// ----------------------------------------------------------------------------
package aes_pkg;

    localparam int TEXT_BITS = 128;
    localparam int LEN_W     = 9;

    typedef enum logic [1:0] {
        WAIT_KEY = 2'd0,
        READY    = 2'd1,
        START    = 2'd2,
        BUSY     = 2'd3
    } ctrl_state_e;

    // The SPI shift register must hold the wider of a key frame and a text frame.
    function automatic int calc_dw(input int nk);
        return (nk * 32 > TEXT_BITS) ? nk * 32 : TEXT_BITS;
    endfunction

endpackage

// File: rtl/aes_spi_frame_cnt.sv
// ----------------------------------------------------------------------------
// aes_spi_frame_cnt
// Counts consecutive cs-low cycles and flags the end of each frame.
// Ports:
//   clk, rst   : system clock, asynchronous active-high reset
//   cs         : SPI chip select, active low, synchronous to clk
//   frame_end  : high in the first cs=1 cycle after one or more cs=0 cycles
//   len        : number of cs=0 cycles in the frame (valid with frame_end)
// ----------------------------------------------------------------------------
module aes_spi_frame_cnt
    import aes_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             cs,
    output logic             frame_end,
    output logic [LEN_W-1:0] len
);

    logic [LEN_W-1:0] len_q, len_d;

    // Saturating count so an overlong frame can never wrap into a legal length.
    always_comb begin
        len_d = len_q;
        if (cs) begin
            len_d = '0;
        end else if (len_q != '1) begin
            len_d = len_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q <= '0;
        end else begin
            len_q <= len_d;
        end
    end

    // len_q is only non-zero after at least one cs=0 cycle.
    assign frame_end = cs && (len_q != '0);
    assign len       = len_q;

endmodule

// File: rtl/aes_spi_ctrl.sv
// ----------------------------------------------------------------------------
// aes_spi_ctrl
// Sequencer between the SPI front-end and the AES core. The first valid frame
// after reset is latched as the key, every later valid frame as a text block
// that starts the core once. The core result is captured and handed back to
// the SPI front-end for shifting out during the next frame.
//
// Optional feature: define AES_CTRL_TIMEOUT_EN to abort a core operation that
// has not answered within 4*(Nr+1) BUSY cycles.
//
// Ports:
//   clk, rst     : system clock, asynchronous active-high reset
//   cs           : SPI chip select, active low
//   spi_data     : parallel view of the SPI shift register
//   aes_done     : core completion pulse, aes_result valid in the same cycle
//   aes_result   : core output block
//   key          : latched key
//   text         : latched input block
//   aes_start    : one-cycle start pulse to the core
//   result       : captured core output
//   result_load  : one-cycle pulse to preload result into the SPI shifter
//   key_valid    : key has been latched
//   busy         : core operation in flight (START and BUSY)
//   frame_err    : one-cycle pulse on a rejected frame or timeout
//
// state    | meaning
// ---------+--------------------------------------------------------------
// WAIT_KEY | no key yet; next valid key-length frame becomes the key
// READY    | key held; next 128-cycle frame becomes the text block
// START    | aes_start asserted for this single cycle
// BUSY     | waiting for aes_done; frames ending here are overruns
// ----------------------------------------------------------------------------
module aes_spi_ctrl
    import aes_pkg::*;
#(
    parameter int Nk = 4,
    parameter int Nr = 10,
    parameter int DW = calc_dw(Nk)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cs,
    input  logic [DW-1:0]        spi_data,
    input  logic                 aes_done,
    input  logic [TEXT_BITS-1:0] aes_result,
    output logic [Nk*32-1:0]     key,
    output logic [TEXT_BITS-1:0] text,
    output logic                 aes_start,
    output logic [TEXT_BITS-1:0] result,
    output logic                 result_load,
    output logic                 key_valid,
    output logic                 busy,
    output logic                 frame_err
);

    localparam int               KEY_BITS = Nk * 32;
    localparam logic [LEN_W-1:0] KEY_LEN  = LEN_W'(KEY_BITS);
    localparam logic [LEN_W-1:0] TEXT_LEN = LEN_W'(TEXT_BITS);

    if (!(Nk == 4 || Nk == 6 || Nk == 8) || Nr < 1) begin : g_bad_param
        $error("aes_spi_ctrl: unsupported Nk/Nr");
    end

    logic             frame_end;
    logic [LEN_W-1:0] len;

    ctrl_state_e          state_q, state_d;
    logic [KEY_BITS-1:0]  key_q, key_d;
    logic [TEXT_BITS-1:0] text_q, text_d;
    logic [TEXT_BITS-1:0] result_q, result_d;
    logic                 key_valid_q, key_valid_d;
    logic                 result_load_q, result_load_d;
    logic                 frame_err_q, frame_err_d;

`ifdef AES_CTRL_TIMEOUT_EN
    localparam int               TO_CYCLES = 4 * (Nr + 1);
    localparam int               TMR_W     = $clog2(TO_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LOAD  = TMR_W'(TO_CYCLES - 1);

    logic [TMR_W-1:0] tmr_q, tmr_d;
`endif

    aes_spi_frame_cnt u_frame_cnt (
        .clk       (clk),
        .rst       (rst),
        .cs        (cs),
        .frame_end (frame_end),
        .len       (len)
    );

    always_comb begin
        state_d       = state_q;
        key_d         = key_q;
        text_d        = text_q;
        result_d      = result_q;
        key_valid_d   = key_valid_q;
        result_load_d = 1'b0;
        frame_err_d   = 1'b0;
`ifdef AES_CTRL_TIMEOUT_EN
        tmr_d         = tmr_q;
`endif

        case (state_q)
            WAIT_KEY: begin
                if (frame_end) begin
                    if (len == KEY_LEN) begin
                        key_d       = spi_data[KEY_BITS-1:0];
                        key_valid_d = 1'b1;
                        state_d     = READY;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end

            READY: begin
                if (frame_end) begin
                    if (len == TEXT_LEN) begin
                        text_d  = spi_data[TEXT_BITS-1:0];
                        state_d = START;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end

            START: begin
                // Unreachable in practice (a frame cannot end two cycles in a
                // row), but an overrun is still an overrun.
                if (frame_end) begin
                    frame_err_d = 1'b1;
                end
                state_d = BUSY;
`ifdef AES_CTRL_TIMEOUT_EN
                tmr_d   = TMR_LOAD;
`endif
            end

            BUSY: begin
                // The frame shifted out the previous result; its input is dropped.
                if (frame_end) begin
                    frame_err_d = 1'b1;
                end
                if (aes_done) begin
                    result_d      = aes_result;
                    result_load_d = 1'b1;
                    state_d       = READY;
                end
`ifdef AES_CTRL_TIMEOUT_EN
                else if (tmr_q == '0) begin
                    frame_err_d = 1'b1;
                    state_d     = READY;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
`endif
            end

            default: state_d = WAIT_KEY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= WAIT_KEY;
            key_q         <= '0;
            text_q        <= '0;
            result_q      <= '0;
            key_valid_q   <= 1'b0;
            result_load_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            key_q         <= key_d;
            text_q        <= text_d;
            result_q      <= result_d;
            key_valid_q   <= key_valid_d;
            result_load_q <= result_load_d;
            frame_err_q   <= frame_err_d;
        end
    end

`ifdef AES_CTRL_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmr_q <= '0;
        end else begin
            tmr_q <= tmr_d;
        end
    end
`endif

    assign key         = key_q;
    assign text        = text_q;
    assign result      = result_q;
    assign key_valid   = key_valid_q;
    assign result_load = result_load_q;
    assign frame_err   = frame_err_q;
    assign aes_start   = (state_q == START);
    assign busy        = (state_q == START) || (state_q == BUSY);

endmodule

// File: tb/tb_aes_spi_ctrl.sv
// ----------------------------------------------------------------------------
// tb_aes_spi_ctrl
// Directed bench for aes_spi_ctrl (Nk=4, Nr=10). Inputs are driven and outputs
// sampled on the falling clock edge. Pulse counters are kept on the rising
// edge so single-cycle pulses can be totalled across a sequence.
// Build with AES_CTRL_TIMEOUT_EN defined to exercise the BUSY timeout.
// ----------------------------------------------------------------------------
module tb_aes_spi_ctrl;
    import aes_pkg::*;

    localparam int NK   = 4;
    localparam int NR   = 10;
    localparam int DW_T = calc_dw(NK);

`ifdef AES_CTRL_TIMEOUT_EN
    localparam int OVR_LEN = 30;
`else
    localparam int OVR_LEN = 128;
`endif

    localparam logic [127:0] KEY0 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KEY1 = 128'hfedcba98765432100123456789abcdef;
    localparam logic [127:0] PT0  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT0  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic               clk = 1'b0;
    logic               rst;
    logic               cs;
    logic [DW_T-1:0]    spi_data;
    logic               aes_done;
    logic [127:0]       aes_result;
    logic [NK*32-1:0]   key;
    logic [127:0]       text;
    logic               aes_start;
    logic [127:0]       result;
    logic               result_load;
    logic               key_valid;
    logic               busy;
    logic               frame_err;

    int checks = 0;
    int errors = 0;
    int n_start = 0;
    int n_load  = 0;
    int n_err   = 0;

    always #5 clk = ~clk;

    aes_spi_ctrl #(.Nk(NK), .Nr(NR)) dut (
        .clk         (clk),
        .rst         (rst),
        .cs          (cs),
        .spi_data    (spi_data),
        .aes_done    (aes_done),
        .aes_result  (aes_result),
        .key         (key),
        .text        (text),
        .aes_start   (aes_start),
        .result      (result),
        .result_load (result_load),
        .key_valid   (key_valid),
        .busy        (busy),
        .frame_err   (frame_err)
    );

    always @(posedge clk) begin
        if (aes_start)   n_start++;
        if (result_load) n_load++;
        if (frame_err)   n_err++;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Holds cs low for n cycles, then returns at the falling edge just after
    // the frame_end edge, when latched values and pulses are visible.
    task automatic send_frame(input int n, input logic [127:0] d);
        spi_data = d;
        cs       = 1'b0;
        repeat (n) @(negedge clk);
        cs = 1'b1;
        @(negedge clk);
    endtask

    // Called in the aes_start cycle; the core answers dly cycles later and the
    // task returns in the result_load cycle.
    task automatic core_reply(input int dly, input logic [127:0] r);
        repeat (dly) @(negedge clk);
        chk("busy before done", busy, 1'b1);
        aes_result = r;
        aes_done   = 1'b1;
        @(negedge clk);
        aes_done   = 1'b0;
        aes_result = '0;
    endtask

    typedef struct {
        int           len;
        logic [127:0] data;
        bit           acc;
        logic [127:0] core_res;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        logic [127:0] exp_text;
        logic [127:0] exp_res;
        int           s0, l0, e0, n_acc, n_rej;

        vecs[0] = '{127, 128'hdeadbeefdeadbeefdeadbeefdeadbeef, 1'b0, '0};
        vecs[1] = '{129, 128'h0badf00d0badf00d0badf00d0badf00d, 1'b0, '0};
        vecs[2] = '{128, PT0, 1'b1, CT0};
        vecs[3] = '{128, 128'hffeeddccbbaa99887766554433221100, 1'b1,
                    128'h0123456789abcdef0011223344556677};
        vecs[4] = '{1,   128'h11111111111111111111111111111111, 1'b0, '0};
        vecs[5] = '{600, 128'h22222222222222222222222222222222, 1'b0, '0};

        rst        = 1'b1;
        cs         = 1'b1;
        spi_data   = '0;
        aes_done   = 1'b0;
        aes_result = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("reset key", key, '0);
        chk("reset text", text, '0);
        chk("reset result", result, '0);
        chk("reset key_valid", key_valid, 1'b0);
        chk("reset busy", busy, 1'b0);
        chk("reset aes_start", aes_start, 1'b0);
        chk("reset result_load", result_load, 1'b0);
        chk("reset frame_err", frame_err, 1'b0);

        // aes_done while waiting for a key is ignored
        aes_result = CT0;
        aes_done   = 1'b1;
        @(negedge clk);
        aes_done   = 1'b0;
        aes_result = '0;
        @(negedge clk);
        chk("stray done result", result, '0);
        chk("stray done load count", n_load, 0);

        // wrong-length key frame is rejected
        send_frame(127, KEY0);
        chk("short key frame_err", frame_err, 1'b1);
        chk("short key key_valid", key_valid, 1'b0);
        chk("short key key", key, '0);

        send_frame(128, KEY0);
        chk("key frame_err", frame_err, 1'b0);
        chk("key key_valid", key_valid, 1'b1);
        chk("key value", key, KEY0);
        chk("key aes_start", aes_start, 1'b0);
        chk("key busy", busy, 1'b0);

        // table of frames applied in READY; accepted rows run the core model
        exp_text = '0;
        exp_res  = '0;
        s0 = n_start;
        e0 = n_err;
        n_acc = 0;
        n_rej = 0;
        for (int i = 0; i < 6; i++) begin
            send_frame(vecs[i].len, vecs[i].data);
            if (vecs[i].acc) begin
                exp_text = vecs[i].data;
                n_acc++;
            end else begin
                n_rej++;
            end
            chk("vec frame_err", frame_err, !vecs[i].acc);
            chk("vec aes_start", aes_start, vecs[i].acc);
            chk("vec busy", busy, vecs[i].acc);
            chk("vec text", text, exp_text);
            chk("vec key", key, KEY0);
            if (vecs[i].acc) begin
                core_reply(11, vecs[i].core_res);
                exp_res = vecs[i].core_res;
                chk("vec result", result, exp_res);
                chk("vec result_load", result_load, 1'b1);
                chk("vec busy after done", busy, 1'b0);
            end else begin
                chk("vec result kept", result, exp_res);
            end
        end
        @(negedge clk);
        chk("vec result_load single", result_load, 1'b0);
        chk("vec start count", n_start - s0, n_acc);
        chk("vec err count", n_err - e0, n_rej);

        // frame ending during BUSY is an overrun; the block in flight completes
        send_frame(128, KEY1);
        chk("ovr aes_start", aes_start, 1'b1);
        l0 = n_load;
        send_frame(OVR_LEN, 128'h33333333333333333333333333333333);
        chk("ovr frame_err", frame_err, 1'b1);
        chk("ovr busy", busy, 1'b1);
        chk("ovr text", text, KEY1);
        @(negedge clk);
        chk("ovr frame_err single", frame_err, 1'b0);
        core_reply(3, 128'h44444444444444444444444444444444);
        exp_res = 128'h44444444444444444444444444444444;
        chk("ovr result", result, exp_res);
        repeat (3) @(negedge clk);
        chk("ovr load count", n_load - l0, 1);

`ifdef AES_CTRL_TIMEOUT_EN
        send_frame(128, 128'h55555555555555555555555555555555);
        chk("to aes_start", aes_start, 1'b1);
        l0 = n_load;
        repeat (44) @(negedge clk);
        chk("to busy at last cycle", busy, 1'b1);
        chk("to no early err", frame_err, 1'b0);
        @(negedge clk);
        chk("to frame_err", frame_err, 1'b1);
        chk("to busy dropped", busy, 1'b0);
        chk("to result kept", result, exp_res);
        repeat (2) @(negedge clk);
        chk("to no result_load", n_load - l0, 0);
        send_frame(128, 128'h66666666666666666666666666666666);
        chk("to restart aes_start", aes_start, 1'b1);
        chk("to restart text", text, 128'h66666666666666666666666666666666);
        core_reply(11, 128'h77777777777777777777777777777777);
        chk("to restart result", result, 128'h77777777777777777777777777777777);
`else
        send_frame(128, 128'h55555555555555555555555555555555);
        chk("wait aes_start", aes_start, 1'b1);
        e0 = n_err;
        repeat (60) @(negedge clk);
        chk("wait still busy", busy, 1'b1);
        chk("wait no err", n_err - e0, 0);
        core_reply(1, 128'h77777777777777777777777777777777);
        chk("wait result", result, 128'h77777777777777777777777777777777);
`endif

        // reset in the middle of a core operation, then a late aes_done
        @(negedge clk);
        send_frame(128, 128'h88888888888888888888888888888888);
        chk("rst aes_start", aes_start, 1'b1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst busy", busy, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        l0 = n_load;
        aes_result = 128'h99999999999999999999999999999999;
        aes_done   = 1'b1;
        @(negedge clk);
        aes_done   = 1'b0;
        aes_result = '0;
        repeat (2) @(negedge clk);
        chk("rst key", key, '0);
        chk("rst text", text, '0);
        chk("rst result", result, '0);
        chk("rst key_valid", key_valid, 1'b0);
        chk("rst busy after done", busy, 1'b0);
        chk("rst no result_load", n_load - l0, 0);

        // WAIT_KEY after reset: the next 128-cycle frame is a key, not a block
        send_frame(128, KEY1);
        chk("rekey key_valid", key_valid, 1'b1);
        chk("rekey key", key, KEY1);
        chk("rekey no aes_start", aes_start, 1'b0);
        chk("rekey text", text, '0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
